icache_mshr_sched: RTL
======================

ICACHE_MSHR_SCHED -- requirements
Module: icache_mshr_sched

Interface
REQ-001 Parameters SHALL be:
- ENTRY_NUM, 8, number of MSHR entries served; power of two, at least 2.
- RD_PLD_W, 32, dataram read payload width (way, index, txnid).
- TX_PLD_W, 96, downstream request payload width.
- CREDIT_NUM, 4, maximum outstanding downstream linefill requests.

REQ-002 Ports SHALL be (IDW = log2(ENTRY_NUM), CW = log2(CREDIT_NUM)+1):
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- v_rd_vld  in  ENTRY_NUM  per-entry dataram read request
- v_rd_pld  in  ENTRY_NUM*RD_PLD_W  per-entry read payload; entry i occupies bits [i*RD_PLD_W +: RD_PLD_W]
- v_rd_rdy  out  ENTRY_NUM  one-hot read grant
- dataram_rd_vld  out  1  read request to dataram
- dataram_rd_rdy  in  1  dataram accept
- dataram_rd_pld  out  RD_PLD_W  granted read payload
- dataram_rd_id  out  IDW  granted entry index
- v_tx_vld  in  ENTRY_NUM  per-entry linefill request
- v_tx_pld  in  ENTRY_NUM*TX_PLD_W  per-entry request payload
- v_tx_rdy  out  ENTRY_NUM  one-hot linefill grant
- downstream_txreq_vld  out  1  linefill request downstream
- downstream_txreq_rdy  in  1  downstream accept
- downstream_txreq_pld  out  TX_PLD_W  granted request payload
- downstream_txreq_id  out  IDW  granted entry index
- linefill_done  in  1  one pulse per completed linefill; returns one credit
- v_alloc_vld  in  ENTRY_NUM  per-entry free flag
- alloc_req  in  1  new miss/hit needs an entry
- entry_en  out  ENTRY_NUM  one-hot allocation strobe
- mshr_full  out  1  no free entry
- credit_cnt  out  CW  outstanding linefills

Function
REQ-003 The read and linefill channels SHALL each be a round-robin arbiter feeding a one-deep output register; the two channels SHALL be independent.

REQ-004 Priority rotation SHALL work as follows:
- Priority SHALL start at pointer ptr and search upward, wrapping from ENTRY_NUM-1 to 0.
- On a grant to entry g, ptr SHALL become (g+1) mod ENTRY_NUM.
- With no grant, ptr SHALL hold.

REQ-005 A channel SHALL grant only when its output register is empty, or is being drained in the same cycle (vld && rdy), giving one transfer per cycle at full throughput.

REQ-006 Grant SHALL be combinational from the v_*_vld inputs: v_*_rdy[g] high for exactly the granted entry, all other bits zero.

REQ-007 Latency SHALL be one cycle: a grant in cycle N loads pld and id into the register, and *_vld is high in cycle N+1.

REQ-008 While *_vld && !*_rdy, the channel's vld, pld and id SHALL hold stable and no new grant SHALL occur.

REQ-009 Linefill credits SHALL be tracked as follows:
- A linefill grant SHALL be blocked when credit_cnt == CREDIT_NUM.
- credit_cnt SHALL increment on a linefill grant and decrement on linefill_done.
- A simultaneous grant and done SHALL leave credit_cnt unchanged.

REQ-010 credit_cnt SHALL saturate at 0 if linefill_done arrives while it is 0 (ignored, no underflow).

REQ-011 Allocation SHALL be combinational:
- mshr_full = ~|v_alloc_vld.
- entry_en SHALL be one-hot at the lowest index with v_alloc_vld set when alloc_req && !mshr_full, and zero otherwise.

REQ-012 An entry requesting on both channels in the same cycle MAY be granted on both.

Reset
REQ-013 In reset, the following SHALL hold:
- dataram_rd_vld and downstream_txreq_vld SHALL be 0.
- Both pld and id registers SHALL be 0.
- Both round-robin pointers SHALL be 0.
- credit_cnt SHALL be 0.

REQ-014 Reset asserted mid-transfer SHALL drop pending output valids immediately, with no handshake completion.

REQ-015 After reset release, the first grant SHALL go to the lowest requesting index.

Verification
REQ-016 The bench SHALL cover:
- Read fairness: v_rd_vld=8'hFF held, dataram_rd_rdy=1 -> dataram_rd_id sequence 0,1,2,...,7,0 with one transfer per cycle.
- Read backpressure: entries 2 and 5 requesting, dataram_rd_rdy=0 for 3 cycles -> id=2 held stable for 3 cycles, v_rd_rdy=0 throughout; after rdy rises, id=5 follows next cycle.
- Credit stall: CREDIT_NUM=4, v_tx_vld=8'h0F, downstream rdy=1, no linefill_done -> 4 requests issued, credit_cnt=4, no further grant; one linefill_done pulse -> exactly one more request, credit_cnt stays 4.
- Simultaneous grant and done at credit_cnt=2 -> credit_cnt remains 2.
- Allocation: v_alloc_vld=8'b1010_0000 with alloc_req=1 -> entry_en=8'b0010_0000; v_alloc_vld=0 -> mshr_full=1, entry_en=0.
- Mid-transfer reset: rst_n low while dataram_rd_vld=1 and rdy=0 -> vld=0 that cycle; after release with v_rd_vld=8'h90 -> first id=4.

Source files
------------

// File: rtl/icache_mshr_sched.sv
// icache_mshr_sched: MSHR-side scheduler for the icache.
// Two independent round-robin channels (dataram reads, downstream linefill
// requests), each feeding a one-deep output register. The linefill channel
// is throttled by a credit counter. A combinational lowest-free allocator
// picks the entry for a new miss/hit.
//
// Handshake: a transfer happens in any cycle where *_vld && *_rdy. While
// *_vld && !*_rdy the output register holds vld/pld/id stable. A channel
// grants (v_*_rdy one-hot) only when its register is empty or draining this
// cycle, so a full-throughput stream moves one transfer per cycle.
module icache_mshr_sched #(
  parameter int ENTRY_NUM  = 8,
  parameter int RD_PLD_W   = 32,
  parameter int TX_PLD_W   = 96,
  parameter int CREDIT_NUM = 4,
  localparam int IDW = $clog2(ENTRY_NUM),
  localparam int CW  = $clog2(CREDIT_NUM) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ENTRY_NUM-1:0]          v_rd_vld,
  input  logic [ENTRY_NUM*RD_PLD_W-1:0] v_rd_pld,
  output logic [ENTRY_NUM-1:0]          v_rd_rdy,
  output logic                          dataram_rd_vld,
  input  logic                          dataram_rd_rdy,
  output logic [RD_PLD_W-1:0]           dataram_rd_pld,
  output logic [IDW-1:0]                dataram_rd_id,
  input  logic [ENTRY_NUM-1:0]          v_tx_vld,
  input  logic [ENTRY_NUM*TX_PLD_W-1:0] v_tx_pld,
  output logic [ENTRY_NUM-1:0]          v_tx_rdy,
  output logic                          downstream_txreq_vld,
  input  logic                          downstream_txreq_rdy,
  output logic [TX_PLD_W-1:0]           downstream_txreq_pld,
  output logic [IDW-1:0]                downstream_txreq_id,
  input  logic                          linefill_done,
  input  logic [ENTRY_NUM-1:0]          v_alloc_vld,
  input  logic                          alloc_req,
  output logic [ENTRY_NUM-1:0]          entry_en,
  output logic                          mshr_full,
  output logic [CW-1:0]                 credit_cnt
);

  // Returns {found, index}: first requester at or above ptr, wrapping.
  // The loop runs from the largest offset down so the smallest offset wins.
  function automatic logic [IDW:0] rr_pick(input logic [ENTRY_NUM-1:0] req,
                                           input logic [IDW-1:0]       ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] cand;
    res = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      cand = ptr + IDW'(i);
      if (req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [IDW-1:0] rd_ptr;
  logic [IDW-1:0] tx_ptr;
  logic [IDW:0]   rd_pick;
  logic [IDW:0]   tx_pick;
  logic [IDW-1:0] rd_idx;
  logic [IDW-1:0] tx_idx;
  logic           rd_open;
  logic           tx_open;
  logic           rd_gnt;
  logic           tx_gnt;
  logic           credit_full;
  logic           done_eff;
  logic           alloc_found;

  assign rd_pick = rr_pick(v_rd_vld, rd_ptr);
  assign tx_pick = rr_pick(v_tx_vld, tx_ptr);
  assign rd_idx  = rd_pick[IDW-1:0];
  assign tx_idx  = tx_pick[IDW-1:0];

  // Register can take a new beat when empty or being drained this cycle.
  assign rd_open = !dataram_rd_vld || dataram_rd_rdy;
  assign tx_open = !downstream_txreq_vld || downstream_txreq_rdy;

  // Credit check uses the registered count, so a done arriving at full
  // credit frees a slot for the following cycle, not the current one.
  assign credit_full = (credit_cnt == CW'(CREDIT_NUM));
  assign done_eff    = linefill_done && (credit_cnt != '0);

  assign rd_gnt = rd_open && rd_pick[IDW];
  assign tx_gnt = tx_open && tx_pick[IDW] && !credit_full;

  assign v_rd_rdy = rd_gnt ? (ENTRY_NUM'(1) << rd_idx) : '0;
  assign v_tx_rdy = tx_gnt ? (ENTRY_NUM'(1) << tx_idx) : '0;

  // Read channel: load the granted beat, clear valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataram_rd_vld <= 1'b0;
      dataram_rd_pld <= '0;
      dataram_rd_id  <= '0;
      rd_ptr         <= '0;
    end else if (rd_gnt) begin
      dataram_rd_vld <= 1'b1;
      dataram_rd_pld <= v_rd_pld[rd_idx*RD_PLD_W +: RD_PLD_W];
      dataram_rd_id  <= rd_idx;
      rd_ptr         <= rd_idx + IDW'(1);
    end else if (dataram_rd_rdy) begin
      dataram_rd_vld <= 1'b0;
    end
  end

  // Linefill channel: same structure as the read channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      downstream_txreq_vld <= 1'b0;
      downstream_txreq_pld <= '0;
      downstream_txreq_id  <= '0;
      tx_ptr               <= '0;
    end else if (tx_gnt) begin
      downstream_txreq_vld <= 1'b1;
      downstream_txreq_pld <= v_tx_pld[tx_idx*TX_PLD_W +: TX_PLD_W];
      downstream_txreq_id  <= tx_idx;
      tx_ptr               <= tx_idx + IDW'(1);
    end else if (downstream_txreq_rdy) begin
      downstream_txreq_vld <= 1'b0;
    end
  end

  // Outstanding linefill count: +1 per grant, -1 per done, floor at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= '0;
    end else begin
      case ({tx_gnt, done_eff})
        2'b10:   credit_cnt <= credit_cnt + CW'(1);
        2'b01:   credit_cnt <= credit_cnt - CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Allocation: strobe the lowest free entry when one is requested.
  always_comb begin
    entry_en    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (alloc_req && v_alloc_vld[i] && !alloc_found) begin
        entry_en[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  assign mshr_full = ~|v_alloc_vld;

endmodule
